// File: rtl/lbmem_stream_if.sv
// Stream-side bundle for lbmem_stream.
//   master : producer side; drives wen/wdata/flush and observes the outputs
//   slave  : lbmem_stream side; samples wen/wdata/flush and drives
//            rdata/valid/count/draining/drop
// WIDTH and DEPTH must match the lbmem_stream instance bound to this bundle.
interface lbmem_stream_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 64
);
   localparam int AW = $clog2(DEPTH);

   logic             wen;
   logic [WIDTH-1:0] wdata;
   logic             flush;
   logic [WIDTH-1:0] rdata;
   logic             valid;
   logic [AW-1:0]    count;
   logic             draining;
   logic             drop;

   modport master (
      output wen, wdata, flush,
      input  rdata, valid, count, draining, drop
   );

   modport slave (
      input  wen, wdata, flush,
      output rdata, valid, count, draining, drop
   );
endinterface

// File: rtl/lbmem_stream.sv
// Line-delay buffer memory. Once LINE samples are held, every accepted
// write returns the sample written LINE writes earlier, one cycle later.
// A flush drains all held samples oldest-first; writes arriving during the
// drain are discarded and flagged on drop.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : lbmem_stream_if.slave (wen, wdata, flush in;
//           rdata, valid, count, draining, drop out)
//
// state  | meaning
// -------+-----------------------------------------------------------
// FILL   | accumulating samples, cnt < LINE, no output
// STREAM | cnt == LINE, each write emits the sample LINE writes older
// DRAIN  | emitting one held sample per cycle until cnt reaches 0
module lbmem_stream #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 64,
   parameter int LINE  = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input logic          clk,
   input logic          rst_n,
   lbmem_stream_if.slave bus
);

   localparam logic [1:0] FILL   = 2'd0;
   localparam logic [1:0] STREAM = 2'd1;
   localparam logic [1:0] DRAIN  = 2'd2;

   localparam logic [AW-1:0] LINE_M1 = AW'(LINE - 1);
   localparam logic [AW-1:0] ONE     = AW'(1);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [1:0]       st, st_nxt;
   logic [AW-1:0]    cnt, cnt_nxt;
   logic [AW-1:0]    waddr;
   logic [AW-1:0]    raddr;
   logic             wr_en, rd_en, drop_nxt;
   logic [WIDTH-1:0] rdata_q;
   logic             valid_q, drop_q;

   // Oldest held sample sits cnt entries behind the write pointer; in
   // STREAM cnt == LINE so this is also the line-delayed tap.
   assign raddr = waddr - cnt;

   always_comb begin
      st_nxt   = st;
      cnt_nxt  = cnt;
      wr_en    = 1'b0;
      rd_en    = 1'b0;
      drop_nxt = 1'b0;
      case (st)
         FILL: begin
            if (bus.wen) begin
               wr_en   = 1'b1;
               cnt_nxt = cnt + ONE;
               // Reaching LINE wins over a simultaneous flush.
               if (cnt == LINE_M1)
                  st_nxt = STREAM;
               else if (bus.flush)
                  st_nxt = DRAIN;
            end else if (bus.flush && cnt != '0) begin
               st_nxt = DRAIN;
            end
         end
         STREAM: begin
            if (bus.wen) begin
               wr_en = 1'b1;
               rd_en = 1'b1;
            end
            if (bus.flush)
               st_nxt = DRAIN;
         end
         DRAIN: begin
            rd_en    = 1'b1;
            cnt_nxt  = cnt - ONE;
            drop_nxt = bus.wen;
            if (cnt == ONE)
               st_nxt = FILL;
         end
         default: begin
            st_nxt  = FILL;
            cnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st      <= FILL;
         cnt     <= '0;
         waddr   <= '0;
         valid_q <= 1'b0;
         rdata_q <= '0;
         drop_q  <= 1'b0;
      end else begin
         st      <= st_nxt;
         cnt     <= cnt_nxt;
         valid_q <= rd_en;
         drop_q  <= drop_nxt;
         if (wr_en)
            waddr <= waddr + ONE;
         if (rd_en)
            rdata_q <= mem[raddr];
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[waddr] <= bus.wdata;
   end

   assign bus.rdata    = rdata_q;
   assign bus.valid    = valid_q;
   assign bus.count    = cnt;
   assign bus.draining = (st == DRAIN);
   assign bus.drop     = drop_q;

endmodule

// File: tb/tb_lbmem_stream.sv
module tb_lbmem_stream;

   localparam int WIDTH = 16;
   localparam int DEPTH = 64;
   localparam int LINE  = 8;

   logic clk;
   logic rst_n;
   int   errs;
   int   checks;

   lbmem_stream_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   lbmem_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LINE(LINE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [WIDTH-1:0] v);
      bus.wen   = 1'b1;
      bus.wdata = v;
      cyc();
      bus.wen   = 1'b0;
   endtask

   task automatic idle();
      bus.wen   = 1'b0;
      bus.flush = 1'b0;
      cyc();
   endtask

   task automatic do_flush();
      bus.flush = 1'b1;
      cyc();
      bus.flush = 1'b0;
   endtask

   logic [15:0] drain_a [8];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      errs      = 0;
      checks    = 0;
      rst_n     = 1'b0;
      bus.wen   = 1'b0;
      bus.wdata = '0;
      bus.flush = 1'b0;
      drain_a   = '{16'h007F, 16'h0080, 16'h0081, 16'h0082,
                    16'h0083, 16'h0084, 16'h0085, 16'h0086};

      #12;
      chk("rst_valid", 32'(bus.valid), 32'd0);
      chk("rst_rdata", 32'(bus.rdata), 32'd0);
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_draining", 32'(bus.draining), 32'd0);
      chk("rst_drop", 32'(bus.drop), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // fill: no output for the first LINE writes
      for (int i = 1; i <= 8; i++) begin
         wr(16'(i));
         chk("fill_valid", 32'(bus.valid), 32'd0);
      end
      chk("fill_count", 32'(bus.count), 32'd8);
      chk("fill_draining", 32'(bus.draining), 32'd0);

      // back-to-back stream, crossing the address wrap twice
      for (int i = 9; i <= 128; i++) begin
         wr(16'(i));
         chk("strm_valid", 32'(bus.valid), 32'd1);
         chk("strm_rdata", 32'(bus.rdata), 32'(i - 8));
         chk("strm_count", 32'(bus.count), 32'd8);
      end

      // sparse writes
      for (int i = 16'h81; i <= 16'h86; i++) begin
         wr(16'(i));
         chk("sparse_valid", 32'(bus.valid), 32'd1);
         chk("sparse_rdata", 32'(bus.rdata), 32'(i - 8));
         idle();
         chk("sparse_idle_valid", 32'(bus.valid), 32'd0);
         chk("sparse_count", 32'(bus.count), 32'd8);
      end

      // drain from STREAM
      do_flush();
      chk("fl1_valid", 32'(bus.valid), 32'd0);
      chk("fl1_draining", 32'(bus.draining), 32'd1);
      chk("fl1_count", 32'(bus.count), 32'd8);
      for (int k = 0; k < 8; k++) begin
         idle();
         chk("dr1_valid", 32'(bus.valid), 32'd1);
         chk("dr1_rdata", 32'(bus.rdata), 32'(drain_a[k]));
         chk("dr1_count", 32'(bus.count), 32'(7 - k));
      end
      chk("dr1_end_draining", 32'(bus.draining), 32'd0);

      // 0x01..0x14 then flush, with writes attempted during the drain
      for (int i = 1; i <= 20; i++) begin
         wr(16'(i));
         if (i <= 8) begin
            chk("w14_fill_valid", 32'(bus.valid), 32'd0);
         end else begin
            chk("w14_valid", 32'(bus.valid), 32'd1);
            chk("w14_rdata", 32'(bus.rdata), 32'(i - 8));
         end
      end
      do_flush();
      chk("fl2_valid", 32'(bus.valid), 32'd0);
      chk("fl2_draining", 32'(bus.draining), 32'd1);
      for (int k = 0; k < 8; k++) begin
         bus.wen   = (k == 2 || k == 5);
         bus.wdata = 16'hDEAD;
         cyc();
         bus.wen = 1'b0;
         chk("dr2_valid", 32'(bus.valid), 32'd1);
         chk("dr2_rdata", 32'(bus.rdata), 32'(16'h000D + k));
         chk("dr2_count", 32'(bus.count), 32'(7 - k));
         chk("dr2_draining", 32'(bus.draining), (k == 7) ? 32'd0 : 32'd1);
         chk("dr2_drop", 32'(bus.drop), (k == 2 || k == 5) ? 32'd1 : 32'd0);
      end
      idle();
      chk("dr2_post_valid", 32'(bus.valid), 32'd0);
      chk("dr2_post_drop", 32'(bus.drop), 32'd0);

      // refill needs LINE fresh writes; dropped samples never surface
      for (int i = 16'h31; i <= 16'h38; i++) begin
         wr(16'(i));
         chk("refill_valid", 32'(bus.valid), 32'd0);
      end
      wr(16'h0039);
      chk("refill_first_valid", 32'(bus.valid), 32'd1);
      chk("refill_first_rdata", 32'(bus.rdata), 32'h0031);
      do_flush();
      for (int k = 0; k < 8; k++) begin
         idle();
         chk("dr3_rdata", 32'(bus.rdata), 32'(16'h0032 + k));
      end
      chk("dr3_count", 32'(bus.count), 32'd0);

      // flush with nothing held is ignored
      do_flush();
      chk("fl0_draining", 32'(bus.draining), 32'd0);
      chk("fl0_valid", 32'(bus.valid), 32'd0);
      chk("fl0_count", 32'(bus.count), 32'd0);

      // partial drain after 3 writes
      wr(16'h00A1);
      wr(16'h00A2);
      wr(16'h00A3);
      do_flush();
      chk("fl3_draining", 32'(bus.draining), 32'd1);
      chk("fl3_count", 32'(bus.count), 32'd3);
      chk("fl3_valid", 32'(bus.valid), 32'd0);
      for (int k = 0; k < 3; k++) begin
         idle();
         chk("dr4_valid", 32'(bus.valid), 32'd1);
         chk("dr4_rdata", 32'(bus.rdata), 32'(16'h00A1 + k));
         chk("dr4_count", 32'(bus.count), 32'(2 - k));
      end
      chk("dr4_draining", 32'(bus.draining), 32'd0);

      // write and flush together in FILL: write lands, then drain
      bus.wen   = 1'b1;
      bus.wdata = 16'h00B1;
      bus.flush = 1'b1;
      cyc();
      bus.wen   = 1'b0;
      bus.flush = 1'b0;
      chk("wfl_draining", 32'(bus.draining), 32'd1);
      chk("wfl_count", 32'(bus.count), 32'd1);
      idle();
      chk("wfl_valid", 32'(bus.valid), 32'd1);
      chk("wfl_rdata", 32'(bus.rdata), 32'h00B1);
      chk("wfl_end_count", 32'(bus.count), 32'd0);

      // asynchronous reset mid-stream
      for (int i = 16'hC1; i <= 16'hCA; i++) wr(16'(i));
      chk("pre_rst_valid", 32'(bus.valid), 32'd1);
      chk("pre_rst_rdata", 32'(bus.rdata), 32'h00C2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(bus.valid), 32'd0);
      chk("arst_rdata", 32'(bus.rdata), 32'd0);
      chk("arst_count", 32'(bus.count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 16'hD1; i <= 16'hD8; i++) begin
         wr(16'(i));
         chk("post_rst_valid", 32'(bus.valid), 32'd0);
      end
      wr(16'h00D9);
      chk("post_rst_first_valid", 32'(bus.valid), 32'd1);
      chk("post_rst_first_rdata", 32'(bus.rdata), 32'h00D1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/lbmem_stream.md
Name: lbmem_stream

Overview:
- Parametrised successor to the fixed 16x64 line-buffer memory.
- Each write is delayed by LINE writes: once LINE samples are held, every new write returns the sample written LINE writes earlier.
- Adds real memory readout, an explicit drain (flush) mode, occupancy reporting and a dropped-write indication.
- Sits between a pixel/sample producer and downstream window/stencil logic that needs line-delayed data.

Parameters:
WIDTH, 16, data width in bits
DEPTH, 64, memory entries; power of two, >= 4
LINE, 8, delay length in writes; 1 <= LINE <= DEPTH-1
AW, $clog2(DEPTH), derived address/counter width; not overridden

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
wen  in  1  write strobe; one sample per cycle
wdata  in  WIDTH  write sample
flush  in  1  request to drain all held samples
rdata  out  WIDTH  output sample, registered
valid  out  1  rdata qualifier; single-cycle per sample
count  out  AW  current occupancy (cnt)
draining  out  1  high while in DRAIN
drop  out  1  registered pulse: a write was discarded during DRAIN

Behaviour:
- Reset (async, rst_n=0): state=FILL, cnt=0, waddr=0, valid=0, rdata=0, drop=0. Memory contents are not reset. Outputs clear immediately, mid-operation included.
- Storage: DEPTH x WIDTH array. Accepted write goes to mem[waddr]; waddr increments mod DEPTH (natural AW-bit wrap).
- Read address: raddr = waddr - cnt, mod DEPTH, AW-bit arithmetic. The read is registered: rdata/valid update the cycle after the issuing edge (latency 1).
- FILL state:
  - wen writes; cnt+1. No output.
  - wen with cnt==LINE-1 moves to STREAM, so cnt=LINE.
  - flush with cnt>0 and wen=0 moves to DRAIN.
  - flush with cnt==0 is ignored.
  - flush with wen: the write is accepted first. If cnt becomes LINE, go to STREAM; else go to DRAIN with the new cnt.
- STREAM state:
  - wen writes mem[waddr] and reads mem[waddr-LINE] in the same cycle; cnt holds LINE. Next cycle: valid=1, rdata = sample from LINE writes earlier.
  - raddr never equals waddr, so there is no read-during-write hazard.
  - No wen: no output, cnt holds.
  - flush (with or without wen): any wen that cycle is processed as above, then move to DRAIN.
- DRAIN state:
  - Each cycle reads mem[waddr-cnt] (oldest first) and decrements cnt; valid=1 the next cycle.
  - When cnt reaches 0, return to FILL; waddr is unchanged.
  - wen during DRAIN is not stored; drop=1 the next cycle.
  - flush is ignored.
- draining = (state==DRAIN).
- count reflects cnt after the edge.
- valid is 0 in every cycle not following a read issue.
- Back-to-back writes in STREAM give continuous valid at full throughput, including across waddr wrap DEPTH-1 -> 0.

Test Plan:
- Reset, then write 0x0001..0x0008 on consecutive cycles (LINE=8) -> valid stays 0, count=8, draining=0.
- Continue with writes 0x0009..0x0080 back-to-back -> from cycle after the 0x0009 write, valid=1 every cycle and rdata = wdata-8 (0x0001..0x0078), correct across waddr wrap at 64.
- In STREAM, wen every other cycle -> valid pulses one cycle after each write only, rdata still wdata-8, count constant 8.
- Write 0x0001..0x0014, then flush with wen=0 -> 8 consecutive valid outputs 0x000D..0x0014, count 8->0, draining high 8 cycles. wen held during drain -> drop pulses, those samples never appear. Then FILL requires 8 fresh writes before output.
- Flush after only 3 writes (0x00A1..0x00A3) -> outputs 0x00A1, 0x00A2, 0x00A3 on 3 cycles, then count=0 in FILL.
- rst_n low mid-STREAM (asynchronous, between edges) -> valid=0, rdata=0, count=0 immediately. After release, 8 writes are needed before the first valid.
